// File: rtl/serial_receiver_pkg.sv
// Shared types and constants for the bit-serial receiver.
package serial_receiver_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } frame_state_e;

  localparam int  BITS_WIDTH = 6;
  localparam logic RXD_IDLE  = 1'b1;
  localparam logic RXC_IDLE  = 1'b0;

  // A frame of zero or one bits ends on its own start sample.
  function automatic logic frame_is_short(input logic [BITS_WIDTH-1:0] bits);
    return (bits <= 6'd1);
  endfunction

endpackage

// File: rtl/serial_receiver_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous pin, plus rise/fall detection
// against a one-cycle-delayed copy of the synchronized level.
module sync_edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain and edge history
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
      prev_r <= RESET_VAL;
    end else begin
      meta_r <= d_i;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign level = sync_r;
  assign rise  = sync_r & ~prev_r;
  assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/serial_receiver.sv
// Bit-serial receiver: programmable baud down-counter with edge resync,
// continuous MSB-first-in shift register and start/length frame tracking.
module serial_receiver
  import serial_receiver_pkg::*;
#(
  parameter int SHIFT_REG_WIDTH = 64,
  parameter int BAUD_RATE_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [5:0]                 bits_i,
  input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
  input  logic                       eedd_i,
  input  logic                       eedc_i,
  input  logic                       rxd_i,
  input  logic                       rxc_i,
  output logic [SHIFT_REG_WIDTH-1:0] dat_o,
  output logic                       idle_o,
  output logic                       sample_to
);

  logic rxd_sync_s, rxd_rise_s, rxd_fall_s;
  logic rxc_sync_s, rxc_rise_s, rxc_fall_s;
  logic unused_s;

  logic [BAUD_RATE_WIDTH-1:0] baud_cnt_r;
  logic [SHIFT_REG_WIDTH-1:0] dat_r;
  logic                       sample_r;
  logic                       idle_r;
  logic                       resync_s;
  logic                       sample_s;
  frame_state_e               state_r, state_nxt_s;
  logic [5:0]                 bitcnt_r, bitcnt_nxt_s;

  sync_edge_detect #(.RESET_VAL(RXD_IDLE)) u_rxd_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (rxd_i),
    .level   (rxd_sync_s),
    .rise    (rxd_rise_s),
    .fall    (rxd_fall_s)
  );

  sync_edge_detect #(.RESET_VAL(RXC_IDLE)) u_rxc_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (rxc_i),
    .level   (rxc_sync_s),
    .rise    (rxc_rise_s),
    .fall    (rxc_fall_s)
  );

  // Only the external clock's rising edge is meaningful for resync.
  assign unused_s = rxc_sync_s ^ rxc_fall_s;

  assign resync_s = (eedd_i & (rxd_rise_s | rxd_fall_s)) | (eedc_i & rxc_rise_s);
  // A resync edge pre-empts a sample due in the same cycle.
  assign sample_s = ~resync_s & (baud_cnt_r == {BAUD_RATE_WIDTH{1'b0}});

  // Bit-time down-counter: half-period load on resync puts samples mid-bit
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      baud_cnt_r <= baud_i;
    end else if (resync_s) begin
      baud_cnt_r <= baud_i >> 1;
    end else if (sample_s) begin
      baud_cnt_r <= baud_i;
    end else begin
      baud_cnt_r <= baud_cnt_r - {{(BAUD_RATE_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Receive shift register and sample strobe
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dat_r    <= {SHIFT_REG_WIDTH{1'b1}};
      sample_r <= 1'b0;
    end else begin
      sample_r <= sample_s;
      if (sample_s) begin
        dat_r <= {rxd_sync_s, dat_r[SHIFT_REG_WIDTH-1:1]};
      end else begin
        dat_r <= dat_r;
      end
    end
  end

  // Frame tracking next-state: start on a 0 while idle, end on the bits_i-th sample
  always_comb begin
    state_nxt_s  = state_r;
    bitcnt_nxt_s = bitcnt_r;
    if (sample_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!rxd_sync_s && !frame_is_short(bits_i)) begin
            state_nxt_s  = ST_FRAME;
            bitcnt_nxt_s = bits_i - 6'd1;
          end else begin
            state_nxt_s  = ST_IDLE;
          end
        end
        ST_FRAME: begin
          bitcnt_nxt_s = bitcnt_r - 6'd1;
          if (bitcnt_r == 6'd1) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_FRAME;
          end
        end
        default: begin
          state_nxt_s  = ST_IDLE;
          bitcnt_nxt_s = 6'd0;
        end
      endcase
    end else begin
      state_nxt_s  = state_r;
      bitcnt_nxt_s = bitcnt_r;
    end
  end

  // Frame state register with registered idle flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= ST_IDLE;
      bitcnt_r <= 6'd0;
      idle_r   <= 1'b1;
    end else begin
      state_r  <= state_nxt_s;
      bitcnt_r <= bitcnt_nxt_s;
      idle_r   <= (state_nxt_s == ST_IDLE);
    end
  end

  assign dat_o     = dat_r;
  assign idle_o    = idle_r;
  assign sample_to = sample_r;

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver: stimulus pushes expected shift/idle
// state per bit, a monitor pops and compares on every sample strobe.
module tb_serial_receiver;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [5:0]  bits_i = 6'd11;
  logic [31:0] baud_i = 32'd49;
  logic        eedd_i = 1'b1;
  logic        eedc_i = 1'b1;
  logic        rxd_i = 1'b1;
  logic        rxc_i = 1'b0;
  logic [63:0] dat_o;
  logic        idle_o;
  logic        sample_to;

  typedef struct {
    logic [63:0] dat;
    logic        idle;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [63:0] exp_dat;

  serial_receiver #(.SHIFT_REG_WIDTH(64), .BAUD_RATE_WIDTH(32)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .bits_i    (bits_i),
    .baud_i    (baud_i),
    .eedd_i    (eedd_i),
    .eedc_i    (eedc_i),
    .rxd_i     (rxd_i),
    .rxc_i     (rxc_i),
    .dat_o     (dat_o),
    .idle_o    (idle_o),
    .sample_to (sample_to)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each strobe with a pending expectation is one vector
  always @(negedge clk) begin
    if (sample_to && sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_vec++;
      if (dat_o !== mon_e.dat || idle_o !== mon_e.idle) begin
        n_bad++;
        $display("FAIL sample dat_o=%h idle_o=%b expected dat=%h idle=%b",
                 dat_o, idle_o, mon_e.dat, mon_e.idle);
      end
    end
  end

  task automatic check1(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", name, act, want);
    end
  endtask

  task automatic push_exp(input logic b, input logic idle);
    exp_t e;
    exp_dat = {b, exp_dat[63:1]};
    e.dat   = exp_dat;
    e.idle  = idle;
    sb_q.push_back(e);
  endtask

  task automatic do_reset(input logic rxd_level);
    @(negedge clk);
    rxd_i   = rxd_level;
    rxc_i   = 1'b0;
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    exp_dat = {64{1'b1}};
  endtask

  task automatic wait_strobe(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sample_to) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic rxc_pulse(input int k, input logic idle);
    rxc_i = 1'b1;
    #200;
    push_exp(1'b0, idle);
    #300;
    rxc_i = 1'b0;
    #500;
  endtask

  initial begin
    logic [11:0] stream;
    logic [11:0] idle_seq;
    bit          ok;
    int          t0;

    // Reset state
    exp_dat = {64{1'b1}};
    repeat (2) @(negedge clk);
    check1("reset_dat", dat_o, {64{1'b1}});
    check1("reset_idle", {63'd0, idle_o}, 64'd1);
    check1("reset_strobe", {63'd0, sample_to}, 64'd0);
    reset_i = 1'b0;

    // Asynchronous 1 Mbps stream, first bit at stream[11]
    repeat (20) @(negedge clk);
    stream   = 12'b010100001010;
    idle_seq = 12'b000000000010;
    #7;
    for (int i = 11; i >= 0; i--) begin
      rxd_i = stream[i];
      #200;
      push_exp(stream[i], idle_seq[i]);
      #800;
    end
    check1("stream12", dat_o, {12'b010100001010, {52{1'b1}}});

    // rxd held low, bits clocked by rxc; pulse 12 starts a back-to-back frame
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      rxc_pulse(k, (k == 11));
    end
    check1("rxc12", dat_o, {12'h000, {52{1'b1}}});

    // Reset in the middle of a frame
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      rxc_pulse(k, 1'b0);
    end
    @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    check1("midreset_dat", dat_o, {64{1'b1}});
    check1("midreset_idle", {63'd0, idle_o}, 64'd1);
    check1("midreset_strobe", {63'd0, sample_to}, 64'd0);
    @(negedge clk);
    reset_i = 1'b0;

    // Free-running strobe spacing with resync disabled
    eedd_i = 1'b0;
    eedc_i = 1'b0;
    do_reset(1'b1);
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          repeat (17) @(posedge clk);
          rxd_i = ~rxd_i;
        end
      end
    join_none
    wait_strobe(200, ok);
    check1("first_strobe", {63'd0, ok}, 64'd1);
    t0 = cyc;
    for (int n = 0; n < 5; n++) begin
      wait_strobe(60, ok);
      check1("strobe_seen", {63'd0, ok}, 64'd1);
      check1("strobe_spacing", 64'(cyc - t0), 64'd50);
      t0 = cyc;
    end

    // baud_i = 0 takes effect at the next reload: strobe every cycle
    baud_i = 32'd0;
    wait_strobe(60, ok);
    check1("baud0_strobe", {63'd0, ok}, 64'd1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check1("baud0_every_cycle", {63'd0, sample_to}, 64'd1);
    end

    check1("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
